jtag_dr_fifo_packer: RTL and testbench

- Sits in the TCK (write) domain of the JTAG debug path, directly upstream of the async-FIFO write pointer.
- Collects a debug-access command shifted through a dedicated data register (DR) from TDI.
- On Update-DR, latches the command and pushes it into the async FIFO as 2 or 3 words, stalling on `full`.
- Returns a status word through the same DR on Capture-DR.

---
 rtl/jtag_dr_fifo_packer.sv | 147 ++++++++++++++
 tb/tb_jtag_dr_fifo_packer.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/jtag_dr_fifo_packer.sv
// ============================================================================
// jtag_dr_fifo_packer: TCK-domain debug DR that packs a shifted command into
// 2-3 async-FIFO words and returns a status word on Capture-DR.
// Revision: 1.0
// ============================================================================
`default_nettype none

module jtag_dr_fifo_packer #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_WIDTH = 32,
  parameter int DR_WIDTH   = 2 + ADDR_WIDTH + DATA_WIDTH
) (
  input  logic                  wclk,
  input  logic                  w_rst,
  input  logic                  dr_sel,
  input  logic                  capture_dr,
  input  logic                  shift_dr,
  input  logic                  update_dr,
  input  logic                  tdi,
  output logic                  tdo,
  input  logic                  full,
  output logic                  winc,
  output logic [FIFO_WIDTH-1:0] wdata,
  output logic                  busy,
  output logic                  overflow,
  output logic                  bad_op
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HDR  = 2'd1,
    S_ADDR = 2'd2,
    S_DATA = 2'd3
  } state_t;

  localparam logic [1:0] c_op_nop   = 2'b00;
  localparam logic [1:0] c_op_read  = 2'b01;
  localparam logic [1:0] c_op_write = 2'b10;
  localparam logic [1:0] c_op_rsvd  = 2'b11;

  state_t                state_q,    state_d;
  logic [DR_WIDTH-1:0]   shift_q,    shift_d;
  logic [1:0]            op_q,       op_d;
  logic [ADDR_WIDTH-1:0] addr_q,     addr_d;
  logic [DATA_WIDTH-1:0] data_q,     data_d;
  logic                  overflow_q, overflow_d;
  logic                  bad_op_q,   bad_op_d;

  logic                  w_capture;
  logic                  w_update;
  logic [1:0]            w_sh_op;

  assign w_capture = dr_sel && capture_dr;
  assign w_update  = dr_sel && update_dr;
  assign w_sh_op   = shift_q[DR_WIDTH-1 -: 2];

  assign busy     = (state_q != S_IDLE);
  assign winc     = busy && !full;
  assign tdo      = shift_q[0];
  assign overflow = overflow_q;
  assign bad_op   = bad_op_q;

  // Capture wins over shift; the status word replaces the whole register.
  always_comb begin
    shift_d = shift_q;
    if (w_capture) begin
      shift_d      = '0;
      shift_d[2:0] = {bad_op_q, overflow_q, busy};
    end else if (dr_sel && shift_dr) begin
      shift_d = {tdi, shift_q[DR_WIDTH-1:1]};
    end
  end

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    addr_d     = addr_q;
    data_d     = data_q;
    overflow_d = overflow_q && !w_capture;
    bad_op_d   = bad_op_q && !w_capture;

    case (state_q)
      S_IDLE: begin
        if (w_update) begin
          op_d   = w_sh_op;
          addr_d = shift_q[DATA_WIDTH +: ADDR_WIDTH];
          data_d = shift_q[DATA_WIDTH-1:0];
          if (w_sh_op == c_op_read || w_sh_op == c_op_write) begin
            state_d = S_HDR;
          end
          if (w_sh_op == c_op_rsvd) begin
            bad_op_d = 1'b1;
          end
        end
      end
      S_HDR: begin
        if (!full) state_d = S_ADDR;
      end
      S_ADDR: begin
        if (!full) state_d = (op_q == c_op_write) ? S_DATA : S_IDLE;
      end
      S_DATA: begin
        if (!full) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // A command arriving mid-packet is dropped; the packet in flight is untouched.
    if (w_update && state_q != S_IDLE) begin
      overflow_d = 1'b1;
    end
  end

  always_comb begin
    wdata = '0;
    case (state_q)
      S_HDR:   wdata[FIFO_WIDTH-1 -: 2] = op_q;
      S_ADDR:  wdata = FIFO_WIDTH'(addr_q);
      S_DATA:  wdata = FIFO_WIDTH'(data_q);
      default: wdata = '0;
    endcase
  end

  always_ff @(posedge wclk) begin
    if (w_rst) begin
      state_q    <= S_IDLE;
      shift_q    <= '0;
      op_q       <= c_op_nop;
      addr_q     <= '0;
      data_q     <= '0;
      overflow_q <= 1'b0;
      bad_op_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      op_q       <= op_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      overflow_q <= overflow_d;
      bad_op_q   <= bad_op_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_jtag_dr_fifo_packer.sv
// ============================================================================
// tb_jtag_dr_fifo_packer: directed, scoreboard-based bench for the DR packer.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_jtag_dr_fifo_packer;

  logic        wclk;
  logic        w_rst;
  logic        dr_sel;
  logic        capture_dr;
  logic        shift_dr;
  logic        update_dr;
  logic        tdi;
  logic        tdo;
  logic        full;
  logic        winc;
  logic [31:0] wdata;
  logic        busy;
  logic        overflow;
  logic        bad_op;

  int          n_cmp;
  int          n_mis;
  logic [31:0] exp_q[$];

  jtag_dr_fifo_packer #(
    .ADDR_WIDTH(32),
    .DATA_WIDTH(32),
    .FIFO_WIDTH(32)
  ) dut (
    .wclk      (wclk),
    .w_rst     (w_rst),
    .dr_sel    (dr_sel),
    .capture_dr(capture_dr),
    .shift_dr  (shift_dr),
    .update_dr (update_dr),
    .tdi       (tdi),
    .tdo       (tdo),
    .full      (full),
    .winc      (winc),
    .wdata     (wdata),
    .busy      (busy),
    .overflow  (overflow),
    .bad_op    (bad_op)
  );

  initial wclk = 1'b0;
  always #5 wclk = ~wclk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge wclk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic shift_cmd(input logic [1:0] op, input logic [31:0] addr, input logic [31:0] data);
    logic [65:0] dr;
    dr       = {op, addr, data};
    dr_sel   = 1'b1;
    shift_dr = 1'b1;
    for (int i = 0; i < 66; i++) begin
      tdi = dr[i];
      tick();
    end
    shift_dr = 1'b0;
    tdi      = 1'b0;
  endtask

  task automatic do_update();
    dr_sel    = 1'b1;
    update_dr = 1'b1;
    tick();
    update_dr = 1'b0;
  endtask

  task automatic do_capture();
    dr_sel     = 1'b1;
    capture_dr = 1'b1;
    tick();
    capture_dr = 1'b0;
  endtask

  // Scoreboard: every write strobe must match the oldest expected word.
  always @(negedge wclk) begin
    if (full === 1'b1) begin
      n_cmp++;
      assert (winc === 1'b0) else begin
        n_mis++;
        $error("FAIL winc_while_full: observed=%b expected=0", winc);
      end
    end
    if (winc === 1'b1) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_mis++;
        $error("FAIL unexpected_push: observed=%h expected=no_push", wdata);
      end else begin
        logic [31:0] e;
        e = exp_q.pop_front();
        assert (wdata === e) else begin
          n_mis++;
          $error("FAIL wdata: observed=%h expected=%h", wdata, e);
        end
      end
    end
  end

  initial begin
    n_cmp      = 0;
    n_mis      = 0;
    w_rst      = 1'b1;
    dr_sel     = 1'b0;
    capture_dr = 1'b0;
    shift_dr   = 1'b0;
    update_dr  = 1'b0;
    tdi        = 1'b0;
    full       = 1'b0;
    tick();
    tick();
    chk("rst_tdo",      32'(tdo),      32'd0);
    chk("rst_winc",     32'(winc),     32'd0);
    chk("rst_wdata",    wdata,         32'd0);
    chk("rst_busy",     32'(busy),     32'd0);
    chk("rst_overflow", 32'(overflow), 32'd0);
    chk("rst_bad_op",   32'(bad_op),   32'd0);
    w_rst = 1'b0;
    tick();

    // Reset in the middle of a WRITE push: only the header word escapes.
    shift_cmd(2'b10, 32'h1111_2222, 32'h3333_4444);
    exp_q.push_back(32'h8000_0000);
    do_update();
    @(negedge wclk);
    #1;
    w_rst = 1'b1;
    tick();
    tick();
    chk("midrst_busy",  32'(busy),  32'd0);
    chk("midrst_winc",  32'(winc),  32'd0);
    chk("midrst_wdata", wdata,      32'd0);
    chk("midrst_tdo",   32'(tdo),   32'd0);
    w_rst = 1'b0;
    tick();
    tick();
    tick();
    chk("midrst_idle", 32'(busy), 32'd0);

    // WRITE without backpressure.
    shift_cmd(2'b10, 32'h1000_0004, 32'hDEAD_BEEF);
    exp_q.push_back(32'h8000_0000);
    exp_q.push_back(32'h1000_0004);
    exp_q.push_back(32'hDEAD_BEEF);
    do_update();
    chk("wr_busy_n1", 32'(busy), 32'd1);
    chk("wr_winc_n1", 32'(winc), 32'd1);
    tick();
    tick();
    tick();
    chk("wr_busy_done", 32'(busy), 32'd0);
    chk("wr_drained", 32'(exp_q.size()), 32'd0);

    // READ with five cycles of backpressure.
    shift_cmd(2'b01, 32'h0000_00F0, 32'h0);
    exp_q.push_back(32'h4000_0000);
    exp_q.push_back(32'h0000_00F0);
    full = 1'b1;
    do_update();
    for (int i = 0; i < 5; i++) begin
      chk("rd_stall_winc",  32'(winc), 32'd0);
      chk("rd_stall_wdata", wdata,     32'h4000_0000);
      if (i < 4) tick();
    end
    full = 1'b0;
    tick();
    tick();
    chk("rd_busy_done", 32'(busy), 32'd0);
    chk("rd_drained", 32'(exp_q.size()), 32'd0);

    // Overflow: second command during a stalled WRITE is dropped.
    full = 1'b1;
    shift_cmd(2'b10, 32'h2000_0008, 32'h1234_5678);
    exp_q.push_back(32'h8000_0000);
    exp_q.push_back(32'h2000_0008);
    exp_q.push_back(32'h1234_5678);
    do_update();
    shift_cmd(2'b01, 32'h0000_FFFF, 32'h0);
    do_update();
    chk("ovf_set",  32'(overflow), 32'd1);
    chk("ovf_busy", 32'(busy),     32'd1);
    do_capture();
    chk("ovf_cleared", 32'(overflow), 32'd0);
    chk("ovf_stat_b0", 32'(tdo), 32'd1);
    shift_dr = 1'b1;
    tdi      = 1'b0;
    tick();
    chk("ovf_stat_b1", 32'(tdo), 32'd1);
    tick();
    chk("ovf_stat_b2", 32'(tdo), 32'd0);
    shift_dr = 1'b0;
    full     = 1'b0;
    tick();
    tick();
    tick();
    tick();
    chk("ovf_busy_done", 32'(busy), 32'd0);
    chk("ovf_drained", 32'(exp_q.size()), 32'd0);

    // Reserved opcode.
    shift_cmd(2'b11, 32'h0, 32'h0000_0003);
    do_update();
    chk("rsv_bad_op", 32'(bad_op), 32'd1);
    chk("rsv_busy",   32'(busy),   32'd0);
    tick();
    chk("rsv_busy2",  32'(busy),   32'd0);

    // Capture and shift together: status {1,0,0} must win.
    capture_dr = 1'b1;
    shift_dr   = 1'b1;
    tdi        = 1'b1;
    tick();
    capture_dr = 1'b0;
    tdi        = 1'b0;
    chk("prio_b0",     32'(tdo),    32'd0);
    chk("prio_bad_op", 32'(bad_op), 32'd0);
    tick();
    chk("prio_b1", 32'(tdo), 32'd0);
    tick();
    chk("prio_b2", 32'(tdo), 32'd1);
    shift_dr = 1'b0;

    // Update ignored while the DR is not selected.
    shift_cmd(2'b01, 32'h0000_00AA, 32'h0);
    dr_sel    = 1'b0;
    update_dr = 1'b1;
    tick();
    update_dr = 1'b0;
    chk("unsel_busy", 32'(busy), 32'd0);
    tick();

    // NOP: nothing pushed, flags untouched.
    shift_cmd(2'b00, 32'h0000_0005, 32'h0000_0006);
    do_update();
    tick();
    chk("nop_busy",     32'(busy),     32'd0);
    chk("nop_overflow", 32'(overflow), 32'd0);
    chk("nop_bad_op",   32'(bad_op),   32'd0);

    // Set event coincident with capture keeps the flag.
    shift_cmd(2'b11, 32'h0, 32'h0);
    capture_dr = 1'b1;
    update_dr  = 1'b1;
    tick();
    capture_dr = 1'b0;
    update_dr  = 1'b0;
    chk("setcap_bad_op", 32'(bad_op), 32'd1);
    chk("setcap_tdo",    32'(tdo),    32'd0);
    tick();
    tick();

    chk("final_drained", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

`default_nettype wire
